// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory-access stage: load/store width codes and LSU states.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BE_W   = XLEN / 8;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned TOCNT_W = 8;

  localparam logic [F3_W-1:0] FUNCT3_B  = 3'b000;
  localparam logic [F3_W-1:0] FUNCT3_H  = 3'b001;
  localparam logic [F3_W-1:0] FUNCT3_W  = 3'b010;
  localparam logic [F3_W-1:0] FUNCT3_BU = 3'b100;
  localparam logic [F3_W-1:0] FUNCT3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store mask/replication plus alignment and
// legality checks, and load byte/half extraction with sign or zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [F3_W-1:0] funct3,
  input  logic            mem_write,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_word,
  output logic [BE_W-1:0] byte_en_c,
  output logic [XLEN-1:0] wdata_c,
  output logic            misalign_c,
  output logic            illegal_c,
  output logic [XLEN-1:0] load_data_c
);

  logic [XLEN-1:0] shifted;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;

  // Bring the addressed byte/half down to bit 0 before extension.
  assign shifted = load_word >> {offset, 3'b000};
  assign lane_b  = shifted[7:0];
  assign lane_h  = shifted[15:0];

  always_comb begin
    byte_en_c   = '0;
    wdata_c     = store_data;
    misalign_c  = 1'b0;
    illegal_c   = 1'b0;
    load_data_c = load_word;
    case (funct3)
      FUNCT3_B, FUNCT3_BU: begin
        byte_en_c   = BE_W'(4'b0001 << offset);
        wdata_c     = {4{store_data[7:0]}};
        illegal_c   = (funct3 == FUNCT3_BU) && mem_write;
        load_data_c = (funct3 == FUNCT3_B) ? {{24{lane_b[7]}}, lane_b}
                                           : {24'h0, lane_b};
      end
      FUNCT3_H, FUNCT3_HU: begin
        byte_en_c   = BE_W'(4'b0011 << offset);
        wdata_c     = {2{store_data[15:0]}};
        misalign_c  = offset[0];
        illegal_c   = (funct3 == FUNCT3_HU) && mem_write;
        load_data_c = (funct3 == FUNCT3_H) ? {{16{lane_h[15]}}, lane_h}
                                           : {16'h0, lane_h};
      end
      FUNCT3_W: begin
        byte_en_c   = 4'b1111;
        misalign_c  = |offset;
      end
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: executes one load or store per Start over a req/ack
// data-memory port, with alignment/legality checks and a bus timeout.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic            MemWrite,
  input  logic [F3_W-1:0] Funct3,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] WriteData,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] ReadData,
  output logic            MisalignErr,
  output logic            BusErr,
  output logic            DReq,
  output logic            DWe,
  output logic [XLEN-1:0] DAddr,
  output logic [BE_W-1:0] DByteEn,
  output logic [XLEN-1:0] DWData,
  input  logic            DAck,
  input  logic [XLEN-1:0] DRData
);

  localparam logic [TOCNT_W-1:0] TO_LAST = TOCNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t           state, state_nxt;
  logic [F3_W-1:0]      f3_q;
  logic                 we_q;
  logic [1:0]           off_q;
  logic [TOCNT_W-1:0]   to_cnt;

  logic [F3_W-1:0]      al_funct3;
  logic                 al_we;
  logic [1:0]           al_off;
  logic [BE_W-1:0]      byte_en_c;
  logic [XLEN-1:0]      wdata_c;
  logic [XLEN-1:0]      load_data_c;
  logic                 misalign_c;
  logic                 illegal_c;
  logic                 reject_c;
  logic                 timeout_c;

  // In IDLE the aligner checks the live request; afterwards it decodes the captured one.
  assign al_funct3 = (state == IDLE) ? Funct3           : f3_q;
  assign al_we     = (state == IDLE) ? MemWrite         : we_q;
  assign al_off    = (state == IDLE) ? ALUResult[1:0]   : off_q;

  lsu_align u_align (
    .funct3      (al_funct3),
    .mem_write   (al_we),
    .offset      (al_off),
    .store_data  (WriteData),
    .load_word   (DRData),
    .byte_en_c   (byte_en_c),
    .wdata_c     (wdata_c),
    .misalign_c  (misalign_c),
    .illegal_c   (illegal_c),
    .load_data_c (load_data_c)
  );

  assign reject_c  = misalign_c | illegal_c;
  assign timeout_c = (state == ACCESS) && !DAck && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = reject_c ? RESP : ACCESS;
      ACCESS:  if (DAck || timeout_c) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      Busy        <= 1'b0;
      Done        <= 1'b0;
      ReadData    <= '0;
      MisalignErr <= 1'b0;
      BusErr      <= 1'b0;
      DReq        <= 1'b0;
      DWe         <= 1'b0;
      DAddr       <= '0;
      DByteEn     <= '0;
      DWData      <= '0;
      f3_q        <= '0;
      we_q        <= 1'b0;
      off_q       <= '0;
      to_cnt      <= '0;
    end else begin
      Busy        <= (state_nxt == ACCESS);
      DReq        <= (state_nxt == ACCESS);
      Done        <= (state_nxt == RESP);
      MisalignErr <= 1'b0;
      BusErr      <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            f3_q   <= Funct3;
            we_q   <= MemWrite;
            off_q  <= ALUResult[1:0];
            to_cnt <= '0;
            if (reject_c) begin
              MisalignErr <= misalign_c;
              BusErr      <= illegal_c;
            end else begin
              DWe     <= MemWrite;
              DAddr   <= {ALUResult[XLEN-1:2], 2'b00};
              DByteEn <= byte_en_c;
              DWData  <= wdata_c;
            end
          end
        end
        ACCESS: begin
          if (DAck) begin
            if (!we_q) ReadData <= load_data_c;
          end else if (timeout_c) begin
            BusErr <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TOCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected completions are queued at
// Start and checked when Done appears; bus fields are checked every DReq cycle.
module tb_load_store_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData;
  logic        Busy, Done, MisalignErr, BusErr, DReq, DWe, DAck;
  logic [31:0] ReadData, DAddr, DWData, DRData;
  logic [3:0]  DByteEn;

  typedef struct {
    int          start;
    int          lat;
    logic [31:0] rd;
    logic        mis;
    logic        bus;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] last_rd = 32'h0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MemWrite(MemWrite), .Funct3(Funct3),
    .ALUResult(ALUResult), .WriteData(WriteData), .Busy(Busy), .Done(Done),
    .ReadData(ReadData), .MisalignErr(MisalignErr), .BusErr(BusErr), .DReq(DReq),
    .DWe(DWe), .DAddr(DAddr), .DByteEn(DByteEn), .DWData(DWData), .DAck(DAck),
    .DRData(DRData)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Completion monitor: every Done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (Done) begin
        if (sb.size() == 0) check("spurious_done", 32'(Done), 32'h0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("latency", 32'(cyc - e.start), 32'(e.lat));
          check("read_data", ReadData, e.rd);
          check("misalign_err", 32'(MisalignErr), 32'(e.mis));
          check("bus_err", 32'(BusErr), 32'(e.bus));
        end
      end else if (MisalignErr || BusErr) begin
        check("flags_without_done", {30'h0, MisalignErr, BusErr}, 32'h0);
      end
    end
  end

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int waits, input logic [31:0] rd,
                     input logic [31:0] exp_load, input logic [3:0] exp_be,
                     input logic [31:0] exp_wd, input logic exp_mis, input logic exp_bus,
                     input int exp_dreq, input bit poke);
    exp_t e;
    int   dreq_cycles;
    bit   done_seen;
    dreq_cycles = 0;
    done_seen   = 0;
    @(negedge clk);
    Start = 1'b1; MemWrite = we; Funct3 = f3; ALUResult = a; WriteData = wd;
    if (!we && !exp_mis && !exp_bus) last_rd = exp_load;
    e.start = cyc;
    e.lat   = (exp_dreq == 0) ? 1 : exp_dreq + 1;
    e.rd    = last_rd;
    e.mis   = exp_mis;
    e.bus   = exp_bus;
    sb.push_back(e);
    for (int k = 0; k < 40 && !done_seen; k++) begin
      @(negedge clk);
      // An extra Start during the access must be ignored.
      Start = poke && (dreq_cycles == 2);
      if (poke) begin Funct3 = 3'b011; ALUResult = 32'h0000_0777; end
      if (DReq) begin
        dreq_cycles++;
        check("d_addr", DAddr, {a[31:2], 2'b00});
        check("d_byte_en", 32'(DByteEn), 32'(exp_be));
        check("d_we", 32'(DWe), 32'(we));
        check("d_wdata", DWData, exp_wd);
        check("busy_in_access", 32'(Busy), 32'h1);
        DAck   = (waits >= 0) && (dreq_cycles == waits + 1);
        DRData = rd;
      end else begin
        DAck = 1'b0;
      end
      if (Done) done_seen = 1;
    end
    Start = 1'b0;
    DAck  = 1'b0;
    if (!done_seen) check("done_timeout", 32'h0, 32'h1);
    check("dreq_cycles", 32'(dreq_cycles), 32'(exp_dreq));
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; MemWrite = 1'b0; Funct3 = '0; ALUResult = '0;
    WriteData = '0; DAck = 1'b0; DRData = '0;
    repeat (3) @(negedge clk);
    check("rst_dreq", 32'(DReq), 32'h0);
    check("rst_done", 32'(Done), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_read_data", ReadData, 32'h0);
    check("rst_daddr", DAddr, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    //  we  f3         addr          wdata         waits rdata         exp_load      be       exp_wd        mis  bus  dreq poke
    txn(0, FUNCT3_W,  32'h0000_0100, 32'h0,         0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 32'h0,         0,   0,   1,  0);
    txn(0, FUNCT3_B,  32'h0000_0203, 32'h0,         0, 32'h8011_2233, 32'hFFFF_FF80, 4'b1000, 32'h0,         0,   0,   1,  0);
    txn(0, FUNCT3_BU, 32'h0000_0203, 32'h0,         0, 32'h8011_2233, 32'h0000_0080, 4'b1000, 32'h0,         0,   0,   1,  0);
    txn(1, FUNCT3_H,  32'h0000_0302, 32'h0000_ABCD, 3, 32'h5555_5555, 32'h0,         4'b1100, 32'hABCD_ABCD, 0,   0,   4,  1);
    txn(0, FUNCT3_W,  32'h0000_0101, 32'h0,         0, 32'h0,         32'h0,         4'b0000, 32'h0,         1,   0,   0,  0);
    txn(0, 3'b011,    32'h0000_0100, 32'h0,         0, 32'h0,         32'h0,         4'b0000, 32'h0,         0,   1,   0,  0);
    txn(1, FUNCT3_HU, 32'h0000_0100, 32'h1234,      0, 32'h0,         32'h0,         4'b0000, 32'h0,         0,   1,   0,  0);
    txn(0, FUNCT3_W,  32'h0000_0400, 32'h0,        -1, 32'h0,         32'h0,         4'b1111, 32'h0,         0,   1,   4,  0);
    txn(0, FUNCT3_H,  32'h0000_0402, 32'h0,         1, 32'h8001_7FFF, 32'hFFFF_8001, 4'b1100, 32'h0,         0,   0,   2,  0);
    txn(0, FUNCT3_HU, 32'h0000_0400, 32'h0,         0, 32'h8001_F00F, 32'h0000_F00F, 4'b0011, 32'h0,         0,   0,   1,  0);
    txn(1, FUNCT3_B,  32'h0000_0001, 32'h1234_56A5, 0, 32'h0,         32'h0,         4'b0010, 32'hA5A5_A5A5, 0,   0,   1,  0);
    txn(1, FUNCT3_W,  32'h0000_0010, 32'h1122_3344, 2, 32'h0,         32'h0,         4'b1111, 32'h1122_3344, 0,   0,   3,  0);

    // Reset in the middle of an access: request drops, no completion follows.
    @(negedge clk);
    Start = 1'b1; MemWrite = 1'b0; Funct3 = FUNCT3_W; ALUResult = 32'h0000_0500;
    @(negedge clk);
    Start = 1'b0;
    check("mid_access_dreq", 32'(DReq), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_dreq", 32'(DReq), 32'h0);
    check("post_reset_busy", 32'(Busy), 32'h0);
    check("post_reset_done", 32'(Done), 32'h0);
    reset   = 1'b0;
    last_rd = 32'h0;

    // Acknowledge while idle must not start anything.
    DAck = 1'b1; DRData = 32'hCAFE_F00D;
    repeat (3) begin
      @(negedge clk);
      check("idle_ack_dreq", 32'(DReq), 32'h0);
      check("idle_ack_done", 32'(Done), 32'h0);
    end
    DAck = 1'b0;
    check("idle_read_data", ReadData, 32'h0);

    txn(0, FUNCT3_W,  32'h0000_0800, 32'h0,         0, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'b1111, 32'h0,         0,   0,   1,  0);
    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
